// File: rtl/switch_debouncer.sv
// ============================================================================
// switch_debouncer : per-bit synchroniser + debouncer with change handshake.
// Optional macro SWITCH_EVENT_COUNT_EN builds the saturating event counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module switch_debouncer #(
  parameter int WORD_W          = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] sw_in,
  output logic [WORD_W-1:0] sw_out,
  output logic              change_valid,
  output logic [WORD_W-1:0] change_mask,
  input  logic              change_ack,
  output logic [7:0]        event_count
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WORD_W-1:0] sync_q, sync_d;
  logic [WORD_W-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_W-1:0]                  sw_out_q, sw_out_d;
  logic [WORD_W-1:0]                  change_mask_q, change_mask_d;
  logic                               change_valid_q, change_valid_d;
  logic [WORD_W-1:0]                  commit;
  logic [WORD_W-1:0]                  sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = sw_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Each bit keeps its own mismatch counter; commit fires on the edge the count saturates.
  always_comb begin
    sw_out_d = sw_out_q;
    cnt_d    = cnt_q;
    commit   = '0;
    for (int i = 0; i < WORD_W; i++) begin
      if (sync_last[i] == sw_out_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        sw_out_d[i] = sync_last[i];
        cnt_d[i]    = '0;
        commit[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // An ack replaces the mask with this edge's commits so nothing committing now is lost.
  always_comb begin
    if (change_ack && change_valid_q) begin
      change_mask_d  = commit;
      change_valid_d = |commit;
    end else begin
      change_mask_d  = change_mask_q | commit;
      change_valid_d = change_valid_q | (|commit);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q         <= '0;
      cnt_q          <= '0;
      sw_out_q       <= '0;
      change_mask_q  <= '0;
      change_valid_q <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      cnt_q          <= cnt_d;
      sw_out_q       <= sw_out_d;
      change_mask_q  <= change_mask_d;
      change_valid_q <= change_valid_d;
    end
  end

  assign sw_out       = sw_out_q;
  assign change_mask  = change_mask_q;
  assign change_valid = change_valid_q;

`ifdef SWITCH_EVENT_COUNT_EN
  logic [7:0]  event_count_q, event_count_d;
  logic [15:0] ev_inc;
  logic [15:0] ev_sum;

  always_comb begin
    ev_inc = '0;
    for (int i = 0; i < WORD_W; i++) begin
      ev_inc = ev_inc + 16'(commit[i]);
    end
    ev_sum        = {8'h00, event_count_q} + ev_inc;
    event_count_d = (ev_sum > 16'h00FF) ? 8'hFF : ev_sum[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      event_count_q <= 8'h00;
    end else begin
      event_count_q <= event_count_d;
    end
  end

  assign event_count = event_count_q;
`else
  assign event_count = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_debouncer.sv
// ============================================================================
// tb_switch_debouncer : table-driven + scoreboard bench for switch_debouncer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_switch_debouncer;

  logic       clock;
  logic       reset;
  logic [7:0] sw_in;
  logic [7:0] sw_out;
  logic       change_valid;
  logic [7:0] change_mask;
  logic       change_ack;
  logic [7:0] event_count;

  int errors = 0;
  int checks = 0;

  switch_debouncer #(
    .WORD_W(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sw_in(sw_in),
    .sw_out(sw_out),
    .change_valid(change_valid),
    .change_mask(change_mask),
    .change_ack(change_ack),
    .event_count(event_count)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  typedef struct {
    logic [7:0] sw;
    logic       v;
    logic [7:0] m;
    logic [7:0] ev;
    string      tag;
  } exp_t;

  typedef struct {
    logic [7:0] sw_in;
    logic       ack;
    exp_t       exp;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  function automatic logic [7:0] ev(input int n);
`ifdef SWITCH_EVENT_COUNT_EN
    return 8'(n);
`else
    return 8'(0 * n);
`endif
  endfunction

  function automatic exp_t mk(input logic [7:0] s, input logic v, input logic [7:0] m,
                              input int n, input string tag);
    exp_t e;
    e.sw = s; e.v = v; e.m = m; e.ev = ev(n); e.tag = tag;
    return e;
  endfunction

  task automatic cmp(input string tag, input string fld, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s %s actual=%h expected=%h", tag, fld, act, want);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard empty actual=0 expected=1");
      return;
    end
    e = sb.pop_front();
    cmp(e.tag, "sw_out", sw_out, e.sw);
    cmp(e.tag, "change_valid", {7'd0, change_valid}, {7'd0, e.v});
    cmp(e.tag, "change_mask", change_mask, e.m);
    cmp(e.tag, "event_count", event_count, e.ev);
  endtask

  task automatic step(input logic [7:0] s, input logic a, input exp_t e);
    @(negedge clock);
    sw_in      = s;
    change_ack = a;
    sb.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  task automatic add(input logic [7:0] s, input logic a, input exp_t e);
    vec_t r;
    r.sw_in = s; r.ack = a; r.exp = e;
    tbl.push_back(r);
  endtask

  initial begin
    // Scenario 2: latency, 0F commits on edge 6, then ack clears.
    for (int k = 1; k <= 5; k++) add(8'h0F, 1'b0, mk(8'h00, 1'b0, 8'h00, 0, "latency_wait"));
    add(8'h0F, 1'b0, mk(8'h0F, 1'b1, 8'h0F, 4, "latency_commit"));
    add(8'h0F, 1'b1, mk(8'h0F, 1'b0, 8'h00, 4, "first_ack"));
    // Scenario 3: 3-cycle glitch on bit 7 is rejected.
    for (int k = 0; k < 3; k++) add(8'h8F, 1'b0, mk(8'h0F, 1'b0, 8'h00, 4, "glitch_high"));
    for (int k = 0; k < 5; k++) add(8'h0F, 1'b0, mk(8'h0F, 1'b0, 8'h00, 4, "glitch_low"));

    reset      = 1'b1;
    sw_in      = 8'hFF;
    change_ack = 1'b0;
    #2;
    sb.push_back(mk(8'h00, 1'b0, 8'h00, 0, "reset_immediate"));
    check_out();
    @(posedge clock);
    #1;
    sb.push_back(mk(8'h00, 1'b0, 8'h00, 0, "reset_held_edge"));
    check_out();
    #5;
    sw_in = 8'h00;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i].sw_in, tbl[i].ack, tbl[i].exp);

    // Scenario 4: bit 0 commits, bit 1 three edges later, then ack.
    for (int k = 1; k <= 3; k++) step(8'h0E, 1'b0, mk(8'h0F, 1'b0, 8'h00, 4, "two_bits_wait"));
    for (int k = 4; k <= 5; k++) step(8'h0C, 1'b0, mk(8'h0F, 1'b0, 8'h00, 4, "two_bits_wait"));
    step(8'h0C, 1'b0, mk(8'h0E, 1'b1, 8'h01, 5, "bit0_commit"));
    for (int k = 7; k <= 8; k++) step(8'h0C, 1'b0, mk(8'h0E, 1'b1, 8'h01, 5, "bit1_wait"));
    step(8'h0C, 1'b0, mk(8'h0C, 1'b1, 8'h03, 6, "bit1_commit"));
    step(8'h0C, 1'b1, mk(8'h0C, 1'b0, 8'h00, 6, "ack_clear"));

    // Scenario 5: ack on the edge bit 4 commits keeps the new change.
    for (int k = 1; k <= 5; k++) step(8'h0D, 1'b0, mk(8'h0C, 1'b0, 8'h00, 6, "bit0_again_wait"));
    step(8'h0D, 1'b0, mk(8'h0D, 1'b1, 8'h01, 7, "bit0_again_commit"));
    for (int k = 7; k <= 11; k++) step(8'h1D, 1'b0, mk(8'h0D, 1'b1, 8'h01, 7, "bit4_wait"));
    step(8'h1D, 1'b1, mk(8'h1D, 1'b1, 8'h10, 8, "ack_on_commit"));
    step(8'h1D, 1'b1, mk(8'h1D, 1'b0, 8'h00, 8, "ack_after"));
    step(8'h1D, 1'b1, mk(8'h1D, 1'b0, 8'h00, 8, "ack_idle_ignored"));

    // Scenario 6: reset while bit 2's counter is at 2.
    for (int k = 1; k <= 4; k++) step(8'h19, 1'b0, mk(8'h1D, 1'b0, 8'h00, 8, "pre_reset_count"));
    #4;
    reset      = 1'b1;
    sw_in      = 8'h04;
    change_ack = 1'b0;
    #1;
    sb.push_back(mk(8'h00, 1'b0, 8'h00, 0, "midcount_reset"));
    check_out();
    @(posedge clock);
    #1;
    sb.push_back(mk(8'h00, 1'b0, 8'h00, 0, "midcount_reset_edge"));
    check_out();
    #5;
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) step(8'h04, 1'b0, mk(8'h00, 1'b0, 8'h00, 0, "post_reset_wait"));
    step(8'h04, 1'b0, mk(8'h04, 1'b1, 8'h04, 1, "post_reset_commit"));

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
